// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory controller slice:
// RAM geometry defaults, FSM state codes and PC helpers.
package imem_pkg;

  localparam int          IMEM_DEPTH  = 256;
  localparam int          IMEM_ADDR_W = 8;
  localparam int          IMEM_DATA_W = 32;
  localparam logic [31:0] IMEM_NOP    = 32'h0000_0000;

  // Controller states, kept as plain codes so older tooling that
  // decodes the state register by value keeps working.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_FILL  = 3'd2;
  localparam state_t S_RUN   = 3'd3;
  localparam state_t S_DRAIN = 3'd4;

  // Byte PC to word index; the low two bits are the byte offset.
  function automatic logic [IMEM_ADDR_W-1:0] pc_to_word(input logic [31:0] pc);
    return pc[IMEM_ADDR_W+1:2];
  endfunction

  // True when the PC lands inside the RAM.
  function automatic logic pc_in_range(input logic [31:0] pc);
    return ~|pc[31:IMEM_ADDR_W+2];
  endfunction

endpackage

// File: rtl/imem_sp_ram.sv
// Single-port instruction RAM, synchronous read with one cycle of
// latency (read-first on a simultaneous write). Contents are not reset.
module imem_sp_ram
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port share the one address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction RAM sequencer: loads a program from the loader stream,
// pads the rest of the RAM with NOPs, then hands the port to fetch.
// The RAM itself sits beside this block and is driven via mem_*.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int                DEPTH    = IMEM_DEPTH,
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter int                DATA_W   = IMEM_DATA_W,
  parameter logic [DATA_W-1:0] NOP_WORD = IMEM_NOP[DATA_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  // loader stream
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  // fetch stage
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_valid,
  output logic              cpu_run,
  // RAM port
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH-1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   cnt_post;
  logic [ADDR_W-1:0] fill_ptr;
  logic              ovf;
  logic              full;
  logic              ld_acc;
  logic              ld_wr;
  logic              ld_end;
  logic              clr_load;
  logic              fire;
  logic              fv_q;
  logic              oor_q;
  logic [DATA_W-1:0] hold_q;
  logic              unused_pc_bits;

  // Byte-offset bits of the PC are meaningless for word fetches.
  assign unused_pc_bits = ^fetch_pc[1:0];

  assign full     = (cnt == DEPTH_C);
  assign ld_ready = (state == S_LOAD);
  assign ld_acc   = ld_ready & ld_valid;
  assign ld_wr    = ld_acc & ~full;
  assign ld_end   = ld_acc & ld_last;
  assign cnt_inc  = cnt + 1'b1;
  assign cnt_post = ld_wr ? cnt_inc : cnt;
  // A fresh load starts from IDLE on ld_start, or after the DRAIN cycle.
  assign clr_load = ((state == S_IDLE) & ld_start) | (state == S_DRAIN);
  assign fire     = (state == S_RUN) & fetch_req;
  assign cpu_run  = (state == S_RUN);

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ld_start) state_nxt = S_LOAD;
      S_LOAD:  if (ld_end) state_nxt = (cnt_post < DEPTH_C) ? S_FILL : S_RUN;
      S_FILL:  if (fill_ptr == LAST_C) state_nxt = S_RUN;
      S_RUN:   if (ld_start) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // RAM port mux: loader, NOP filler or fetch owns the single port.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_LOAD: begin
        mem_we    = ld_wr;
        mem_addr  = cnt[ADDR_W-1:0];
        mem_wdata = ld_data;
      end
      S_FILL: begin
        mem_we    = 1'b1;
        mem_addr  = fill_ptr;
        mem_wdata = NOP_WORD;
      end
      S_RUN:   mem_addr = fetch_pc[ADDR_W+1:2];
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Load word counter and sticky overflow; FILL never touches these.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr_load) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (ld_acc) begin
      if (full) ovf <= 1'b1;
      else      cnt <= cnt_inc;
    end
  end

  // Fill pointer picks up where the program ended.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        fill_ptr <= '0;
    else if (ld_end)                 fill_ptr <= cnt_post[ADDR_W-1:0];
    else if (state == S_FILL)        fill_ptr <= fill_ptr + 1'b1;
  end

  // Fetch tracking: valid and range flag line up with the RAM's read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fv_q  <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      fv_q <= fire;
      if (fire) oor_q <= |fetch_pc[31:ADDR_W+2];
    end
  end

  // Last delivered instruction, so fetch_instr holds between fetches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      hold_q <= '0;
    else if (fv_q) hold_q <= fetch_instr;
  end

  // RAM data is already registered; muxing it here keeps one-cycle latency.
  assign fetch_instr  = fv_q ? (oor_q ? NOP_WORD : mem_rdata) : hold_q;
  assign fetch_valid  = fv_q;
  assign word_count   = cnt;
  assign err_overflow = ovf;

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl with the instruction RAM alongside it.
// Expected RAM writes and fetch results are queued as stimulus is driven
// and matched by a negedge monitor; each test task also checks inline.
module tb_imem_ctrl;
  import imem_pkg::*;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk, rst;
  logic        ld_start, ld_valid, ld_last, ld_ready;
  logic [31:0] ld_data;
  logic        fetch_req, fetch_valid, cpu_run;
  logic [31:0] fetch_pc, fetch_instr;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic [8:0]  word_count;
  logic        err_overflow;

  int  checks = 0;
  int  errors = 0;
  wr_t wq[$];
  logic [31:0] fq[$];
  wr_t mw;
  logic [31:0] mf;

  imem_ctrl dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid), .cpu_run(cpu_run),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .word_count(word_count), .err_overflow(err_overflow)
  );

  imem_sp_ram ram (
    .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every RAM write and every fetch result is matched
  // in order against the queued expectations.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: addr=%0d data=%h, no write expected", mem_addr, mem_wdata);
      end else begin
        mw = wq.pop_front();
        if (mem_addr !== mw.a || mem_wdata !== mw.d) begin
          errors++;
          $display("FAIL wr_match: got addr=%0d data=%h, want addr=%0d data=%h",
                   mem_addr, mem_wdata, mw.a, mw.d);
        end
      end
    end
    if (fetch_valid === 1'b1) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected: instr=%h, no fetch expected", fetch_instr);
      end else begin
        mf = fq.pop_front();
        if (fetch_instr !== mf) begin
          errors++;
          $display("FAIL fetch_match: got %h, want %h", fetch_instr, mf);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    fetch_req = 0; fetch_pc = '0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_run, ld_ready, mem_we, fetch_valid, err_overflow} !== 5'b0 ||
        mem_addr !== 8'd0 || fetch_instr !== 32'd0 || word_count !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: run=%b rdy=%b we=%b fv=%b ovf=%b addr=%0d instr=%h cnt=%0d, want all 0",
               cpu_run, ld_ready, mem_we, fetch_valid, err_overflow, mem_addr, fetch_instr, word_count);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_fill;
    logic [31:0] prog [3];
    int fill_cycles;
    prog[0] = 32'h8001_060A; prog[1] = 32'h0401_0800; prog[2] = 32'h0C01_1800;
    ld_start = 1; tick(); ld_start = 0;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1 || cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL load_entry: ld_ready=%b cpu_run=%b, want 1 0", ld_ready, cpu_run);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = prog[i]; ld_last = (i == 2);
      wq.push_back('{a: 8'(i), d: prog[i]});
      tick();
    end
    ld_valid = 0; ld_last = 0;
    for (int a = 3; a < 256; a++) wq.push_back('{a: 8'(a), d: 32'h0});
    fill_cycles = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cpu_run === 1'b1) break;
      if (mem_we === 1'b1) fill_cycles++;
      @(posedge clk); #1;
    end
    checks++;
    if (cpu_run !== 1'b1 || fill_cycles != 253) begin
      errors++;
      $display("FAIL fill_len: cpu_run=%b fill_cycles=%0d, want 1 253", cpu_run, fill_cycles);
    end
    checks++;
    if (word_count !== 9'd3 || wq.size() != 0) begin
      errors++;
      $display("FAIL load_count: word_count=%0d pending_writes=%0d, want 3 0", word_count, wq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_stream;
    logic [31:0] exp [4];
    exp[0] = 32'h8001_060A; exp[1] = 32'h0401_0800; exp[2] = 32'h0C01_1800; exp[3] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      fetch_req = (i < 4);
      fetch_pc  = 32'(4 * i);
      if (i < 4) fq.push_back(exp[i]);
      @(negedge clk);
      checks++;
      if (fetch_valid !== (i > 0) || (i < 4 && mem_addr !== pc_to_word(fetch_pc)) || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL fetch_timing[%0d]: fv=%b addr=%0d we=%b, want fv=%b addr=%0d we=0",
                 i, fetch_valid, mem_addr, mem_we, (i > 0), pc_to_word(fetch_pc));
      end
      @(posedge clk); #1;
    end
    fetch_req = 0;
  endtask

  task automatic test_hold_and_oor;
    fetch_req = 1; fetch_pc = 32'h8; fq.push_back(32'h0C01_1800);
    tick(); fetch_req = 0;
    tick();
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0C01_1800) begin
      errors++;
      $display("FAIL instr_hold: fv=%b instr=%h, want 0 0c011800", fetch_valid, fetch_instr);
    end
    @(posedge clk); #1;
    fetch_req = 1; fetch_pc = 32'h0000_0400; fq.push_back(32'h0);
    tick(); fetch_req = 0;
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_instr !== 32'h0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL fetch_oor: fv=%b instr=%h ovf=%b, want 1 00000000 0",
               fetch_valid, fetch_instr, err_overflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_drain_restart;
    ld_start = 1; fetch_req = 1; fetch_pc = 32'h4; fq.push_back(32'h0401_0800);
    tick();
    ld_start = 0; fetch_req = 1; fetch_pc = 32'h8;
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_instr !== 32'h0401_0800 || cpu_run !== 1'b0 ||
        mem_we !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_cycle: fv=%b instr=%h run=%b we=%b rdy=%b, want 1 04010800 0 0 0",
               fetch_valid, fetch_instr, cpu_run, mem_we, ld_ready);
    end
    @(posedge clk); #1;
    fetch_req = 0;
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b0 || cpu_run !== 1'b0 || ld_ready !== 1'b1 ||
        word_count !== 9'd0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL drain_to_load: fv=%b run=%b rdy=%b cnt=%0d ovf=%b, want 0 0 1 0 0",
               fetch_valid, cpu_run, ld_ready, word_count, err_overflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 257; i++) begin
      ld_valid = 1; ld_data = 32'hA500_0000 | 32'(i); ld_last = (i == 256);
      if (i < 256) wq.push_back('{a: 8'(i), d: 32'hA500_0000 | 32'(i)});
      if (i == 256) begin
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || err_overflow !== 1'b0 || word_count !== 9'd256) begin
          errors++;
          $display("FAIL ovf_drop: we=%b ovf=%b cnt=%0d, want 0 0 256", mem_we, err_overflow, word_count);
        end
      end
      tick();
    end
    ld_valid = 0; ld_last = 0;
    @(negedge clk);
    checks++;
    if (cpu_run !== 1'b1 || err_overflow !== 1'b1 || word_count !== 9'd256 || wq.size() != 0) begin
      errors++;
      $display("FAIL ovf_run: run=%b ovf=%b cnt=%0d pending=%0d, want 1 1 256 0",
               cpu_run, err_overflow, word_count, wq.size());
    end
    @(posedge clk); #1;
    fetch_req = 1; fetch_pc = 32'h3FC; fq.push_back(32'hA500_00FF);
    tick();
    fetch_pc = 32'h0; fq.push_back(32'hA500_0000);
    tick();
    fetch_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_fill;
    ld_start = 1; tick(); ld_start = 0;
    tick();
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1 || err_overflow !== 1'b0 || word_count !== 9'd0) begin
      errors++;
      $display("FAIL reload_clear: rdy=%b ovf=%b cnt=%0d, want 1 0 0", ld_ready, err_overflow, word_count);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      ld_valid = 1; ld_data = 32'h5A00_0000 | 32'(i); ld_last = (i == 99);
      wq.push_back('{a: 8'(i), d: 32'h5A00_0000 | 32'(i)});
      tick();
    end
    ld_valid = 0; ld_last = 0;
    wq.push_back('{a: 8'd100, d: 32'h0});
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'd100) begin
      errors++;
      $display("FAIL fill_start: we=%b addr=%0d, want 1 100", mem_we, mem_addr);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (cpu_run !== 1'b0 || mem_we !== 1'b0 || word_count !== 9'd0 || ld_ready !== 1'b0 || mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL async_abort: run=%b we=%b cnt=%0d rdy=%b addr=%0d, want 0 0 0 0 0",
               cpu_run, mem_we, word_count, ld_ready, mem_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || cpu_run !== 1'b0 || ld_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: we=%b run=%b rdy=%b, want 0 0 0", n, mem_we, cpu_run, ld_ready);
      end
    end
  endtask

  task automatic test_scoreboard_empty;
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: pending writes=%0d fetches=%0d, want 0 0", wq.size(), fq.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_fill();
    test_fetch_stream();
    test_hold_and_oor();
    test_drain_restart();
    test_overflow();
    test_reset_mid_fill();
    test_scoreboard_empty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
